// File: rtl/bank_burst_scheduler.sv
// bank_burst_scheduler: round-robin arbiter that runs one whole BL-beat
// read or write burst at a time into a flattened per-bank DRAM chip model
// and returns read beats tagged with the owning requester.
module bank_burst_scheduler #(
    parameter int BGWIDTH      = 2,
    parameter int BAWIDTH      = 2,
    parameter int ADDRWIDTH    = 17,
    parameter int COLWIDTH     = 10,
    parameter int DEVICE_WIDTH = 4,
    parameter int BL           = 8,
    parameter int NREQ         = 4,
    parameter int RDLAT        = 1,
    localparam int BKW         = BGWIDTH + BAWIDTH,
    localparam int BANKS       = 2 ** BKW,
    localparam int IDW         = $clog2(NREQ),
    localparam int BLW         = $clog2(BL),
    localparam int DW          = DEVICE_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NREQ-1:0]                req_valid,
    output logic [NREQ-1:0]                req_ready,
    input  logic [NREQ-1:0]                req_wr,
    input  logic [NREQ*BGWIDTH-1:0]        req_bg,
    input  logic [NREQ*BAWIDTH-1:0]        req_ba,
    input  logic [NREQ*ADDRWIDTH-1:0]      req_row,
    input  logic [NREQ*COLWIDTH-1:0]       req_col,
    input  logic [NREQ*BL*DW-1:0]          req_wdata,
    output logic [BANKS-1:0]               chip_rd_o_wr,
    output logic [BANKS*DW-1:0]            chip_dqin,
    output logic [BANKS*ADDRWIDTH-1:0]     chip_row,
    output logic [BANKS*COLWIDTH-1:0]      chip_column,
    input  logic [BANKS*DW-1:0]            chip_dqout,
    output logic                           rd_valid,
    output logic [DW-1:0]                  rd_data,
    output logic [IDW-1:0]                 rd_id,
    output logic                           rd_last,
    output logic                           busy
);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t                state;
    logic [IDW-1:0]        ptr;
    logic [BLW-1:0]        beat;

    // captured request for the burst in flight
    logic                  cap_wr;
    logic [IDW-1:0]        cap_id;
    logic [BKW-1:0]        cap_bank;
    logic [ADDRWIDTH-1:0]  cap_row;
    logic [COLWIDTH-1:0]   cap_col;
    logic [BL*DW-1:0]      cap_wdata;

    // arbitration
    logic                  gnt_v;
    logic [IDW-1:0]        gnt_idx;
    logic [IDW-1:0]        cand;

    // beat to be placed on the chip buses at the next edge
    logic                  drv;
    logic                  d_wr;
    logic [BKW-1:0]        d_bank;
    logic [ADDRWIDTH-1:0]  d_row;
    logic [COLWIDTH-1:0]   d_col;
    logic [BL*DW-1:0]      d_wdata;
    logic [BLW-1:0]        d_beat;

    logic [BANKS-1:0]           n_rd_o_wr;
    logic [BANKS*DW-1:0]        n_dqin;
    logic [BANKS*ADDRWIDTH-1:0] n_row;
    logic [BANKS*COLWIDTH-1:0]  n_col;

    // read-return tracking: a read beat is on the chip buses this cycle
    logic                  issue_rd;
    logic                  issue_last;
    logic [RDLAT-1:0]      pipe_v;
    logic [RDLAT-1:0]      pipe_last;

    // Rotating priority search starting just after the last winner.
    always_comb begin
        gnt_v   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDW'((int'(ptr) + i) % NREQ);
            if (!gnt_v && req_valid[cand]) begin
                gnt_v   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Accept pulse only in IDLE; held off during reset so nothing is lost.
    assign req_ready = (state == IDLE && gnt_v && !rst) ? (NREQ'(1) << gnt_idx) : '0;
    assign busy      = (state != IDLE);

    // Select what the next edge should drive: beat 0 of a new grant or the
    // following beat of the current burst; otherwise the buses go quiet.
    always_comb begin
        drv     = 1'b0;
        d_wr    = 1'b0;
        d_bank  = '0;
        d_row   = '0;
        d_col   = '0;
        d_wdata = '0;
        d_beat  = '0;
        if (state == IDLE && gnt_v) begin
            drv     = 1'b1;
            d_wr    = req_wr[gnt_idx];
            d_bank  = {req_bg[gnt_idx*BGWIDTH +: BGWIDTH], req_ba[gnt_idx*BAWIDTH +: BAWIDTH]};
            d_row   = req_row[gnt_idx*ADDRWIDTH +: ADDRWIDTH];
            d_col   = req_col[gnt_idx*COLWIDTH +: COLWIDTH];
            d_wdata = req_wdata[gnt_idx*BL*DW +: BL*DW];
            d_beat  = '0;
        end else if (state == BURST && beat != BLW'(BL-1)) begin
            drv     = 1'b1;
            d_wr    = cap_wr;
            d_bank  = cap_bank;
            d_row   = cap_row;
            d_col   = cap_col;
            d_wdata = cap_wdata;
            d_beat  = beat + BLW'(1);
        end
    end

    // Place the selected beat into its bank slice; every other slice stays 0.
    // Column low bits wrap inside the BL-aligned block.
    always_comb begin
        n_rd_o_wr = '0;
        n_dqin    = '0;
        n_row     = '0;
        n_col     = '0;
        if (drv) begin
            n_rd_o_wr[d_bank]                    = d_wr;
            n_dqin[d_bank*DW +: DW]              = d_wr ? d_wdata[d_beat*DW +: DW] : '0;
            n_row[d_bank*ADDRWIDTH +: ADDRWIDTH] = d_row;
            n_col[d_bank*COLWIDTH +: COLWIDTH]   = {d_col[COLWIDTH-1:BLW], d_col[BLW-1:0] + d_beat};
        end
    end

    // FSM, registered chip buses and the read-return pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= IDW'(NREQ-1);
            beat         <= '0;
            cap_wr       <= 1'b0;
            cap_id       <= '0;
            cap_bank     <= '0;
            cap_row      <= '0;
            cap_col      <= '0;
            cap_wdata    <= '0;
            chip_rd_o_wr <= '0;
            chip_dqin    <= '0;
            chip_row     <= '0;
            chip_column  <= '0;
            issue_rd     <= 1'b0;
            issue_last   <= 1'b0;
            pipe_v       <= '0;
            pipe_last    <= '0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            rd_id        <= '0;
            rd_last      <= 1'b0;
        end else begin
            chip_rd_o_wr <= n_rd_o_wr;
            chip_dqin    <= n_dqin;
            chip_row     <= n_row;
            chip_column  <= n_col;
            issue_rd     <= drv && !d_wr;
            issue_last   <= drv && (d_beat == BLW'(BL-1));

            // chip_dqout for a beat is valid RDLAT cycles after it was driven
            pipe_v[0]    <= issue_rd;
            pipe_last[0] <= issue_last;
            for (int k = 1; k < RDLAT; k++) begin
                pipe_v[k]    <= pipe_v[k-1];
                pipe_last[k] <= pipe_last[k-1];
            end

            rd_valid <= pipe_v[RDLAT-1];
            rd_last  <= pipe_v[RDLAT-1] && pipe_last[RDLAT-1];
            rd_data  <= pipe_v[RDLAT-1] ? chip_dqout[cap_bank*DW +: DW] : '0;
            rd_id    <= pipe_v[RDLAT-1] ? cap_id : '0;

            case (state)
                IDLE: begin
                    if (gnt_v) begin
                        cap_wr    <= d_wr;
                        cap_id    <= gnt_idx;
                        cap_bank  <= d_bank;
                        cap_row   <= d_row;
                        cap_col   <= d_col;
                        cap_wdata <= d_wdata;
                        ptr       <= gnt_idx;
                        beat      <= '0;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (beat == BLW'(BL-1)) begin
                        beat  <= '0;
                        state <= cap_wr ? IDLE : DRAIN;
                    end else begin
                        beat <= beat + BLW'(1);
                    end
                end
                DRAIN: begin
                    // leave one cycle after the last read beat is presented
                    if (rd_valid && rd_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bank_burst_scheduler.sv
// Directed bench for bank_burst_scheduler with a small RDLAT=1 chip model.
module tb_bank_burst_scheduler;
    localparam int BGW = 2, BAW = 2, AW = 17, CW = 10, DW = 4, BL = 8, NREQ = 4, RDLAT = 1;
    localparam int BANKS = 16, IDW = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid, req_ready, req_wr;
    logic [NREQ*BGW-1:0]    req_bg;
    logic [NREQ*BAW-1:0]    req_ba;
    logic [NREQ*AW-1:0]     req_row;
    logic [NREQ*CW-1:0]     req_col;
    logic [NREQ*BL*DW-1:0]  req_wdata;
    logic [BANKS-1:0]       chip_rd_o_wr;
    logic [BANKS*DW-1:0]    chip_dqin;
    logic [BANKS*AW-1:0]    chip_row;
    logic [BANKS*CW-1:0]    chip_column;
    logic [BANKS*DW-1:0]    chip_dqout;
    logic                   rd_valid, rd_last, busy;
    logic [DW-1:0]          rd_data;
    logic [IDW-1:0]         rd_id;

    int checks = 0;
    int failures = 0;

    bank_burst_scheduler #(
        .BGWIDTH(BGW), .BAWIDTH(BAW), .ADDRWIDTH(AW), .COLWIDTH(CW),
        .DEVICE_WIDTH(DW), .BL(BL), .NREQ(NREQ), .RDLAT(RDLAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
        .req_wdata(req_wdata),
        .chip_rd_o_wr(chip_rd_o_wr), .chip_dqin(chip_dqin), .chip_row(chip_row),
        .chip_column(chip_column), .chip_dqout(chip_dqout),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_id(rd_id), .rd_last(rd_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Chip model: per-bank storage keyed by column, registered read (RDLAT=1).
    logic [DW-1:0]       mem [BANKS][1024];
    logic [BANKS*DW-1:0] dq_m = '0;
    assign chip_dqout = dq_m;
    always @(posedge clk) begin
        for (int b = 0; b < BANKS; b++) begin
            if (chip_rd_o_wr[b]) mem[b][chip_column[b*CW +: CW]] <= chip_dqin[b*DW +: DW];
            dq_m[b*DW +: DW] <= mem[b][chip_column[b*CW +: CW]];
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req_valid = '0; req_wr = '0; req_bg = '0; req_ba = '0;
        req_row = '0; req_col = '0; req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [BGW-1:0] bg,
                           input logic [BAW-1:0] ba, input logic [AW-1:0] row,
                           input logic [CW-1:0] col, input logic [BL*DW-1:0] wd);
        req_valid[i] = 1'b1;
        req_wr[i] = wr;
        req_bg[i*BGW +: BGW] = bg;
        req_ba[i*BAW +: BAW] = ba;
        req_row[i*AW +: AW] = row;
        req_col[i*CW +: CW] = col;
        req_wdata[i*BL*DW +: BL*DW] = wd;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 40; n++) begin
            if (!busy) break;
            step();
        end
        check("idle_reached", busy, 0);
    endtask

    function automatic logic [511:0] f_slot(input int bank, input int w, input logic [31:0] v);
        return 512'(v) << (bank * w);
    endfunction

    function automatic logic [7:0] quiet();
        return {busy, rd_valid, rd_last, |rd_data, |chip_rd_o_wr, |chip_dqin, |chip_row, |chip_column};
    endfunction

    logic [DW-1:0] wbeat [8] = '{4'h3, 4'hA, 4'h5, 4'hC, 4'h1, 4'hF, 4'h0, 4'h7};
    logic [CW-1:0] colA  [8] = '{10'h006, 10'h007, 10'h000, 10'h001, 10'h002, 10'h003, 10'h004, 10'h005};
    logic [CW-1:0] colB  [8] = '{10'h3FE, 10'h3FF, 10'h3F8, 10'h3F9, 10'h3FA, 10'h3FB, 10'h3FC, 10'h3FD};

    initial begin
        int n, first_cyc, last_cyc, gnt_cyc, ngr;
        int gidx [5];
        int gcyc [5];

        // ---- reset, then quiet idle
        rst = 1'b1;
        clear_reqs();
        step(); step();
        check("reset_quiet", quiet(), 0);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check("idle_quiet", quiet(), 0);
            check("idle_ready", req_ready, 0);
            step();
        end

        // ---- write burst from req0 to bank 5 (bg1 ba1), row 1, col 0
        set_req(0, 1'b1, 2'd1, 2'd1, 17'd1, 10'd0, 32'h70F1C5A3);
        #1;
        check("wr_ready", req_ready, 4'b0001);
        step();
        clear_reqs();
        for (int b = 0; b < 8; b++) begin
            check("wr_strobe", chip_rd_o_wr, 16'h0020);
            check("wr_dqin", chip_dqin, f_slot(5, DW, 32'(wbeat[b])));
            check("wr_row", chip_row, f_slot(5, AW, 1));
            check("wr_col", chip_column, f_slot(5, CW, b));
            check("wr_busy", busy, 1);
            step();
        end
        check("wr_done_quiet", quiet(), 0);

        // ---- read it back: beats 3,A,5,C,1,F,0,7 with id 0
        set_req(0, 1'b0, 2'd1, 2'd1, 17'd1, 10'd0, '0);
        #1;
        check("rd_ready", req_ready, 4'b0001);
        step();
        clear_reqs();
        n = 0; first_cyc = -1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (cyc <= 8) begin
                check("rd_col", chip_column, f_slot(5, CW, cyc - 1));
                check("rd_strobe_dq", {|chip_rd_o_wr, |chip_dqin}, 0);
            end
            if (rd_valid) begin
                if (n == 0) first_cyc = cyc;
                if (n < 8) begin
                    check("rd_data", rd_data, wbeat[n]);
                    check("rd_id", rd_id, 0);
                    check("rd_last", rd_last, (n == 7));
                end
                n++;
            end
            step();
        end
        check("rd_beats", n, 8);
        check("rd_latency", first_cyc, 3);
        check("rd_done_busy", busy, 0);

        // ---- column wrap: req1 reads at col 0x006 then 0x3FE (bank 0, row 2)
        set_req(1, 1'b0, 2'd0, 2'd0, 17'd2, 10'h006, '0);
        #1;
        check("wrapA_ready", req_ready, 4'b0010);
        step();
        clear_reqs();
        for (int b = 0; b < 8; b++) begin
            check("wrapA_col", chip_column, f_slot(0, CW, 32'(colA[b])));
            check("wrapA_row", chip_row, f_slot(0, AW, 2));
            step();
        end
        wait_idle();
        set_req(1, 1'b0, 2'd0, 2'd0, 17'd2, 10'h3FE, '0);
        #1;
        check("wrapB_ready", req_ready, 4'b0010);
        step();
        clear_reqs();
        for (int b = 0; b < 8; b++) begin
            check("wrapB_col", chip_column, f_slot(0, CW, 32'(colB[b])));
            step();
        end
        wait_idle();

        // ---- req1 read in flight, req2 raised during DRAIN
        set_req(1, 1'b0, 2'd0, 2'd1, 17'd3, 10'h010, '0);
        #1;
        check("drain_rd_ready", req_ready, 4'b0010);
        step();
        clear_reqs();
        last_cyc = -1; gnt_cyc = -1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (cyc == 9) begin
                set_req(2, 1'b1, 2'd0, 2'd2, 17'd4, 10'd0, 32'h12345678);
                #1;
            end
            if (rd_valid && rd_last) begin
                last_cyc = cyc;
                check("drain_last_id", rd_id, 1);
            end
            if (req_ready != 0) begin
                gnt_cyc = cyc;
                check("drain_ready", req_ready, 4'b0100);
                break;
            end
            step();
        end
        check("drain_last_cyc", last_cyc, 10);
        check("drain_gnt_cyc", gnt_cyc, 11);
        step();
        clear_reqs();
        wait_idle();

        // ---- reset on beat 3 of a read burst
        set_req(0, 1'b0, 2'd0, 2'd0, 17'd0, 10'd0, '0);
        #1;
        check("rst_rd_ready", req_ready, 4'b0001);
        step();
        clear_reqs();
        step(); step(); step();
        check("rst_beat3_col", chip_column, f_slot(0, CW, 3));
        rst = 1'b1;
        step();
        check("rst_quiet", quiet(), 0);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            check("rst_no_rdvalid", rd_valid, 0);
            step();
        end

        // ---- all four requesters writing continuously: order 0,1,2,3,0
        set_req(0, 1'b1, 2'd0, 2'd0, 17'd5, 10'd0, 32'h11111111);
        set_req(3, 1'b1, 2'd3, 2'd3, 17'd5, 10'd0, 32'h44444444);
        #1;
        check("ptr_reset_prio", req_ready, 4'b0001);
        set_req(1, 1'b1, 2'd1, 2'd0, 17'd5, 10'd0, 32'h22222222);
        set_req(2, 1'b1, 2'd2, 2'd0, 17'd5, 10'd0, 32'h33333333);
        #1;
        ngr = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            check("rr_onehot", $onehot0(req_ready), 1);
            if (req_ready != 0) begin
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) gidx[ngr] = i;
                gcyc[ngr] = cyc;
                ngr++;
                if (ngr == 5) break;
            end
            step();
        end
        check("rr_count", ngr, 5);
        if (ngr == 5) begin
            check("rr_order", {gidx[0][3:0], gidx[1][3:0], gidx[2][3:0], gidx[3][3:0], gidx[4][3:0]}, 20'h01230);
            for (int k = 1; k < 5; k++) check("rr_gap", gcyc[k] - gcyc[k-1], BL + 1);
        end
        step();
        clear_reqs();
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
